// File: rtl/hilo_unit_pkg.sv
// Shared ALU control codes, HI/LO sequencer states and counter sizing helper.
package hilo_unit_pkg;

  localparam logic [3:0] CTRL_AND = 4'd0;
  localparam logic [3:0] CTRL_OR  = 4'd1;
  localparam logic [3:0] CTRL_ADD = 4'd2;
  localparam logic [3:0] CTRL_MUL = 4'd3;
  localparam logic [3:0] CTRL_DIV = 4'd4;
  localparam logic [3:0] CTRL_SUB = 4'd6;
  localparam logic [3:0] CTRL_SLT = 4'd7;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_WAIT = 2'd1,
    DIV_WAIT = 2'd2
  } hilo_state_e;

  // Never returns 0 so a 1-cycle latency still gets a real register.
  function automatic int cnt_width(input int mul_lat, input int div_lat);
    int m;
    m = (mul_lat > div_lat) ? mul_lat : div_lat;
    return ($clog2(m) < 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/hilo_lat_counter.sv
// Loadable down-counter with zero flag; load wins over decrement, 1-cycle update.
// No backpressure: caller decides when to load or decrement.
module hilo_lat_counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (dec && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign count = count_q;
  assign zero  = (count_q == '0);

endmodule

// File: rtl/hilo_unit.sv
// HI/LO register unit: drives ALU Control for MUL_LAT/DIV_LAT cycles, then captures High/Low.
// Reads return one cycle after acceptance; any request while busy is refused via stall.
module hilo_unit
  import hilo_unit_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              op_valid,
  input  logic              op_is_div,
  input  logic [DATA_W-1:0] alu_high,
  input  logic [DATA_W-1:0] alu_low,
  output logic [3:0]        alu_ctrl,
  output logic              alu_ctrl_en,
  input  logic              mt_valid,
  input  logic              mt_sel,
  input  logic [DATA_W-1:0] mt_data,
  input  logic              mf_req,
  input  logic              mf_sel,
  output logic [DATA_W-1:0] mf_data,
  output logic              mf_valid,
  output logic              busy,
  output logic              stall,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int CNT_W = cnt_width(MUL_LAT, DIV_LAT);

  hilo_state_e       state_q, state_d;
  logic              idle;
  logic              cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0]  cnt_load_val;
  logic [CNT_W-1:0]  cnt_val;
  logic              capture;
  logic [DATA_W-1:0] hi_q, lo_q, mf_data_q;
  logic              mf_valid_q;

  assign idle         = (state_q == IDLE);
  assign cnt_load     = idle && op_valid;
  assign cnt_load_val = op_is_div ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
  assign cnt_dec      = !idle && !cnt_zero;
  assign capture      = !idle && cnt_zero;

  hilo_lat_counter #(
    .W (CNT_W)
  ) u_lat_counter (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .count    (cnt_val),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    alu_ctrl    = CTRL_AND;
    alu_ctrl_en = 1'b0;
    busy        = 1'b0;
    case (state_q)
      IDLE: begin
        if (op_valid) begin
          state_d = op_is_div ? DIV_WAIT : MUL_WAIT;
        end
      end
      MUL_WAIT: begin
        busy        = 1'b1;
        alu_ctrl_en = 1'b1;
        alu_ctrl    = CTRL_MUL;
        if (cnt_zero) state_d = IDLE;
      end
      DIV_WAIT: begin
        busy        = 1'b1;
        alu_ctrl_en = 1'b1;
        alu_ctrl    = CTRL_DIV;
        if (cnt_zero) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign stall = busy && (op_valid || mt_valid || mf_req);

  // Divide result arrives as {quotient, remainder}; MIPS keeps quotient in LO.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (capture) begin
      if (state_q == DIV_WAIT) begin
        hi_q <= alu_low;
        lo_q <= alu_high;
      end else begin
        hi_q <= alu_high;
        lo_q <= alu_low;
      end
    end else if (idle && mt_valid) begin
      if (mt_sel) hi_q <= mt_data;
      else        lo_q <= mt_data;
    end
  end

  // Samples the pre-edge register, so a same-cycle MT returns the old value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mf_data_q  <= '0;
      mf_valid_q <= 1'b0;
    end else begin
      mf_valid_q <= idle && mf_req;
      if (idle && mf_req) begin
        mf_data_q <= mf_sel ? hi_q : lo_q;
      end
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign mf_data  = mf_data_q;
  assign mf_valid = mf_valid_q;

endmodule

// File: tb/tb_hilo_unit.sv
// Directed bench for hilo_unit with a behavioural ALU and an MF read scoreboard.
module tb_hilo_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        op_valid, op_is_div;
  logic [31:0] alu_high, alu_low;
  logic [3:0]  alu_ctrl;
  logic        alu_ctrl_en;
  logic        mt_valid, mt_sel;
  logic [31:0] mt_data;
  logic        mf_req, mf_sel;
  logic [31:0] mf_data;
  logic        mf_valid, busy, stall;
  logic [31:0] hi, lo;

  logic [31:0] opa, opb;
  logic [31:0] exp_hi, exp_lo;
  logic [31:0] sb_q[$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  hilo_unit #(.DATA_W(32), .MUL_LAT(4), .DIV_LAT(32)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .op_valid    (op_valid),
    .op_is_div   (op_is_div),
    .alu_high    (alu_high),
    .alu_low     (alu_low),
    .alu_ctrl    (alu_ctrl),
    .alu_ctrl_en (alu_ctrl_en),
    .mt_valid    (mt_valid),
    .mt_sel      (mt_sel),
    .mt_data     (mt_data),
    .mf_req      (mf_req),
    .mf_sel      (mf_sel),
    .mf_data     (mf_data),
    .mf_valid    (mf_valid),
    .busy        (busy),
    .stall       (stall),
    .hi          (hi),
    .lo          (lo)
  );

  // Behavioural ALU: signed multiply, unsigned divide (quotient on High).
  logic [63:0] prod;
  always @* begin
    prod     = $signed({{32{opa[31]}}, opa}) * $signed({{32{opb[31]}}, opb});
    alu_high = 32'h0;
    alu_low  = 32'h0;
    if (alu_ctrl == 4'd3) begin
      alu_high = prod[63:32];
      alu_low  = prod[31:0];
    end else if (alu_ctrl == 4'd4 && opb != 32'h0) begin
      alu_high = opa / opb;
      alu_low  = opa % opb;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mf_valid) begin
      if (sb_q.size() == 0) begin
        check("mf_unexpected", 32'd1, 32'd0);
      end else begin
        check("mf_data", mf_data, sb_q.pop_front());
      end
    end
  end

  task automatic run_op(input logic is_div, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input logic [31:0] eh, input logic [31:0] el);
    opa = a; opb = b; op_is_div = is_div; op_valid = 1'b1;
    check("issue_stall", {31'h0, stall}, 32'd0);
    @(negedge clk);
    op_valid = 1'b0;
    for (int i = 0; i < lat; i++) begin
      check("op_busy", {31'h0, busy}, 32'd1);
      check("op_ctrl", {28'h0, alu_ctrl}, is_div ? 32'd4 : 32'd3);
      check("op_ctrl_en", {31'h0, alu_ctrl_en}, 32'd1);
      @(negedge clk);
    end
    exp_hi = eh; exp_lo = el;
    check("done_busy", {31'h0, busy}, 32'd0);
    check("done_ctrl_en", {31'h0, alu_ctrl_en}, 32'd0);
    check("done_ctrl", {28'h0, alu_ctrl}, 32'd0);
    check("done_hi", hi, exp_hi);
    check("done_lo", lo, exp_lo);
  endtask

  initial begin
    reset_n = 1'b0; op_valid = 1'b0; op_is_div = 1'b0;
    mt_valid = 1'b0; mt_sel = 1'b0; mt_data = 32'h0;
    mf_req = 1'b0; mf_sel = 1'b0; opa = 32'h0; opb = 32'h0;
    exp_hi = 32'h0; exp_lo = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'h0, busy}, 32'd0);
    check("rst_ctrl_en", {31'h0, alu_ctrl_en}, 32'd0);
    check("rst_ctrl", {28'h0, alu_ctrl}, 32'd0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_mf_valid", {31'h0, mf_valid}, 32'd0);
    check("rst_mf_data", mf_data, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    run_op(1'b0, 32'd7, 32'd6, 4, 32'h0, 32'd42);
    run_op(1'b0, 32'hFFFFFFFF, 32'd2, 4, 32'hFFFFFFFF, 32'hFFFFFFFE);

    // Divide with an MFHI held against the stall.
    opa = 32'd100; opb = 32'd7; op_is_div = 1'b1; op_valid = 1'b1;
    @(negedge clk);
    op_valid = 1'b0; mf_req = 1'b1; mf_sel = 1'b1;
    for (int i = 0; i < 32; i++) begin
      check("div_busy", {31'h0, busy}, 32'd1);
      check("div_stall", {31'h0, stall}, 32'd1);
      check("div_ctrl", {28'h0, alu_ctrl}, 32'd4);
      @(negedge clk);
    end
    exp_hi = 32'd2; exp_lo = 32'd14;
    check("div_idle_stall", {31'h0, stall}, 32'd0);
    check("div_hi", hi, exp_hi);
    check("div_lo", lo, exp_lo);
    sb_q.push_back(exp_hi);
    @(negedge clk);
    mf_req = 1'b0;

    // MTLO and MFLO together: read sees the old LO.
    mt_valid = 1'b1; mt_sel = 1'b0; mt_data = 32'hA5A5A5A5;
    mf_req = 1'b1; mf_sel = 1'b0;
    sb_q.push_back(exp_lo);
    exp_lo = 32'hA5A5A5A5;
    @(negedge clk);
    mt_valid = 1'b0;
    sb_q.push_back(exp_lo);
    @(negedge clk);
    mf_req = 1'b0;
    check("mt_lo", lo, exp_lo);
    @(negedge clk);

    // Op, MTHI and MFHI in one cycle: write lands, read is pre-op, capture overwrites.
    opa = 32'd3; opb = 32'd5; op_is_div = 1'b0; op_valid = 1'b1;
    mt_valid = 1'b1; mt_sel = 1'b1; mt_data = 32'hDEADBEEF;
    mf_req = 1'b1; mf_sel = 1'b1;
    sb_q.push_back(exp_hi);
    @(negedge clk);
    op_valid = 1'b0; mt_valid = 1'b0; mf_req = 1'b0;
    check("combo_mt_hi", hi, 32'hDEADBEEF);
    check("combo_busy", {31'h0, busy}, 32'd1);
    repeat (4) @(negedge clk);
    exp_hi = 32'h0; exp_lo = 32'd15;
    check("combo_hi", hi, exp_hi);
    check("combo_lo", lo, exp_lo);

    // Reset in the middle of a multiply.
    opa = 32'd9; opb = 32'd9; op_valid = 1'b1;
    @(negedge clk);
    op_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_busy", {31'h0, busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    exp_hi = 32'h0; exp_lo = 32'h0;
    check("midrst_busy", {31'h0, busy}, 32'd0);
    check("midrst_ctrl_en", {31'h0, alu_ctrl_en}, 32'd0);
    check("midrst_hi", hi, exp_hi);
    check("midrst_lo", lo, exp_lo);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    check("postrst_busy", {31'h0, busy}, 32'd0);
    check("postrst_hi", hi, exp_hi);
    check("postrst_lo", lo, exp_lo);

    @(negedge clk);
    check("sb_drain", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hilo_unit.md
Name: hilo_unit

Overview:
- HI/LO result register unit that drives the ALU's 4-bit Control for multiply/divide and consumes its 32-bit High/Low result pair.
- Holds the ALU's Control code steady for a fixed number of cycles per operation, then captures High/Low into architectural HI/LO.
- Serves MTHI/MTLO writes and MFHI/MFLO reads, and stalls the pipeline while an operation is in flight.

Parameters:
- DATA_W, 32, width of HI, LO and the ALU result halves.
- MUL_LAT, 4, cycles the ALU is given to settle a multiply (>=1).
- DIV_LAT, 32, cycles the ALU is given to settle a divide (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- op_valid  in  1  issue mult/div this cycle.
- op_is_div  in  1  1 = divide, 0 = multiply; sampled with op_valid.
- alu_high  in  DATA_W  ALU High output.
- alu_low  in  DATA_W  ALU Low output.
- alu_ctrl  out  4  Control code to the ALU.
- alu_ctrl_en  out  1  1 = this block owns the ALU Control mux.
- mt_valid  in  1  MTHI/MTLO write.
- mt_sel  in  1  0 = LO, 1 = HI.
- mt_data  in  DATA_W  write data.
- mf_req  in  1  MFHI/MFLO read request.
- mf_sel  in  1  0 = LO, 1 = HI.
- mf_data  out  DATA_W  read data, registered.
- mf_valid  out  1  mf_data valid pulse.
- busy  out  1  operation in flight.
- stall  out  1  request refused this cycle; requester holds it.
- hi  out  DATA_W  architectural HI.
- lo  out  DATA_W  architectural LO.

Behaviour:
- Reset (async, reset_n=0): state IDLE, counter 0, hi=lo=0, mf_data=0, mf_valid=0, busy=0, alu_ctrl=0, alu_ctrl_en=0. An operation in flight is abandoned and no capture occurs.
- States: IDLE, MUL_WAIT, DIV_WAIT.
- IDLE with op_valid at cycle t:
  - Next state is MUL_WAIT or DIV_WAIT.
  - Counter loads MUL_LAT-1 or DIV_LAT-1.
- WAIT states:
  - busy=1, alu_ctrl_en=1.
  - alu_ctrl = 4'd3 in MUL_WAIT, 4'd4 in DIV_WAIT.
  - Counter decrements each cycle.
  - In the cycle where the counter is 0, the clock edge captures the result and returns the state to IDLE.
  - busy spans cycles t+1 .. t+LAT; the new HI/LO is visible from t+LAT+1.
- Capture mapping:
  - Multiply: hi<=alu_high, lo<=alu_low.
  - Divide: the ALU presents quotient on High and remainder on Low, so the unit swaps them: lo<=alu_high (quotient), hi<=alu_low (remainder), per MIPS convention.
- IDLE outputs: alu_ctrl=0, alu_ctrl_en=0, busy=0.
- stall = busy & (op_valid | mt_valid | mf_req), combinational. Stalled requests have no effect; the requester re-presents them.
- mt_valid in IDLE: the selected register is written at the clock edge.
- mf_req accepted in IDLE:
  - mf_valid=1 next cycle, mf_data = selected register value before that edge (read-before-write).
  - mf_valid is a one-cycle pulse; mf_data holds its last value otherwise.
- Simultaneous events in IDLE:
  - op_valid + mt_valid: the write happens and the op starts; capture later overwrites.
  - op_valid + mf_req: the read returns the pre-op value.
  - mt_valid + mf_req on the same register: returns the old value.
- Back-to-back: op_valid may be accepted in the first IDLE cycle after completion. There is no IDLE-skipping.
- Counter width: $clog2(max(MUL_LAT,DIV_LAT)).

Decomposition:
- Shared package: ALU control constants CTRL_AND=0, CTRL_OR=1, CTRL_ADD=2, CTRL_MUL=3, CTRL_DIV=4, CTRL_SUB=6, CTRL_SLT=7; hilo state enum {IDLE, MUL_WAIT, DIV_WAIT}.
- One sub-module: hilo_lat_counter, a loadable down-counter with a zero flag.

Test Plan:
- Multiply: op_valid, op_is_div=0; bench ALU model A=7, B=6 -> alu_ctrl=3 for 4 cycles, busy 4 cycles, then hi=0, lo=42.
- Signed multiply: A=32'hFFFFFFFF, B=2 -> after capture hi=32'hFFFFFFFF, lo=32'hFFFFFFFE.
- Divide 100/7: bench ALU drives High=14, Low=2 -> alu_ctrl=4 for 32 cycles, then lo=14, hi=2.
- mf_req (mf_sel=1) raised during DIV_WAIT:
  - stall=1 every busy cycle.
  - Accepted first IDLE cycle; mf_valid next cycle with mf_data=2.
- mt_valid, mt_sel=0, data 32'hA5A5A5A5 with mf_req, mf_sel=0 same cycle:
  - mf_data returns the old lo.
  - The following read returns 32'hA5A5A5A5.
- reset_n pulsed low mid-MUL_WAIT -> busy=0, alu_ctrl_en=0, hi=lo=0 immediately; no later capture.
